// File: rtl/csr_uart_master.sv
// csr_uart_master
//   Host-side CSR bus initiator. Parses framed commands from the UART RX PHY,
//   issues single-cycle CSR read/write strobes and returns ACK, NAK or read
//   data to the UART TX PHY. An optional trailing CRC-8 byte (poly 0x07,
//   init 0x00, MSB-first) protects the frames and the responses.
//
//   Ports:
//     clk, rst_n           clock, asynchronous active-low reset
//     rx_valid, rx_data    received byte strobe / byte
//     tx_valid, tx_data    byte to transmit, held until tx_ready
//     tx_ready             TX PHY accepts the byte on tx_valid && tx_ready
//     crc_en               frames and responses carry a CRC byte
//     csr_wen, csr_ren     single-cycle CSR write / read strobes
//     csr_addr, csr_wdata  CSR byte address / write data
//     csr_rdata            CSR read data, valid in the csr_ren cycle
//     rx_crc_error         pulse on frame CRC mismatch
//     rx_illegal_cmd       pulse on bad opcode, unaligned address or timeout
//     rx_overrun           pulse when a byte is dropped during EXEC/RESP
//     busy                 high whenever the FSM is not idle
module csr_uart_master #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  input  logic              crc_en,
  output logic              csr_wen,
  output logic              csr_ren,
  output logic [ADDR_W-1:0] csr_addr,
  output logic [31:0]       csr_wdata,
  input  logic [31:0]       csr_rdata,
  output logic              rx_crc_error,
  output logic              rx_illegal_cmd,
  output logic              rx_overrun,
  output logic              busy
);

  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc ^ b;
    for (int unsigned i = 0; i < 8; i++)
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    return c;
  endfunction

  function automatic logic [7:0] crc8_word(input logic [31:0] w);
    logic [7:0] c;
    c = 8'h00;
    for (int unsigned i = 0; i < 4; i++)
      c = crc8_byte(c, w[8*i +: 8]);
    return c;
  endfunction

  localparam int unsigned TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0]  OP_WR   = 8'h57;
  localparam logic [7:0]  OP_RD   = 8'h52;
  localparam logic [7:0]  ACK     = 8'hAC;
  localparam logic [7:0]  ACK_CRC = crc8_byte(8'h00, ACK);
  localparam logic [7:0]  NAK_CRC = 8'hE1;
  localparam logic [7:0]  NAK_ILL = 8'hE2;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_CHK, S_EXEC, S_RESP
  } state_t;

  state_t          state, state_n;
  logic            crc_mode;
  logic            is_write;
  logic [7:0]      crc_acc;
  logic [7:0]      addr_r;
  logic [31:0]     wdata_r;
  logic [1:0]      byte_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic [4:0][7:0] resp_buf;
  logic [2:0]      resp_idx;
  logic [2:0]      resp_last;

  logic            tmo_hit;
  logic            fin;
  logic            nak;
  logic [7:0]      nak_code;
  logic            crc_err_n, ill_n, ovr_n;
  logic [1:0]      addr_lo;

  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // fin marks acceptance of the last frame byte. When crc_mode is off the
  // CHK state is skipped entirely so EXEC follows the last byte directly.
  always_comb begin
    state_n   = state;
    fin       = 1'b0;
    nak       = 1'b0;
    nak_code  = NAK_ILL;
    crc_err_n = 1'b0;
    ill_n     = 1'b0;
    ovr_n     = 1'b0;
    // In ADDR the address byte is still on rx_data
    addr_lo   = (state == S_ADDR) ? rx_data[1:0] : addr_r[1:0];
    case (state)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_data == OP_WR || rx_data == OP_RD) begin
            state_n = S_ADDR;
          end else begin
            ill_n = 1'b1;
            nak   = 1'b1;
          end
        end
      end
      S_ADDR: begin
        if (rx_valid) begin
          if (is_write)      state_n = S_DATA;
          else if (crc_mode) state_n = S_CHK;
          else               fin     = 1'b1;
        end else if (tmo_hit) begin
          ill_n   = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          if (byte_cnt != 2'd3) state_n = S_DATA;
          else if (crc_mode)    state_n = S_CHK;
          else                  fin     = 1'b1;
        end else if (tmo_hit) begin
          ill_n   = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_CHK: begin
        if (rx_valid) begin
          if (rx_data != crc_acc) begin
            crc_err_n = 1'b1;
            nak       = 1'b1;
            nak_code  = NAK_CRC;
          end else begin
            fin = 1'b1;
          end
        end else if (tmo_hit) begin
          ill_n   = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_EXEC: begin
        ovr_n   = rx_valid;
        state_n = S_RESP;
      end
      S_RESP: begin
        ovr_n = rx_valid;
        if (tx_ready && resp_idx == resp_last) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if (fin) begin
      if (addr_lo != 2'b00) begin
        ill_n = 1'b1;
        nak   = 1'b1;
      end else begin
        state_n = S_EXEC;
      end
    end
    if (nak) state_n = S_RESP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_mode       <= 1'b0;
      is_write       <= 1'b0;
      crc_acc        <= '0;
      addr_r         <= '0;
      wdata_r        <= '0;
      byte_cnt       <= '0;
      tmo_cnt        <= '0;
      resp_buf       <= '0;
      resp_idx       <= '0;
      resp_last      <= '0;
      rx_crc_error   <= 1'b0;
      rx_illegal_cmd <= 1'b0;
      rx_overrun     <= 1'b0;
    end else begin
      rx_crc_error   <= crc_err_n;
      rx_illegal_cmd <= ill_n;
      rx_overrun     <= ovr_n;
      case (state)
        S_IDLE: begin
          if (rx_valid) begin
            crc_mode <= crc_en;
            is_write <= (rx_data == OP_WR);
            crc_acc  <= crc8_byte(8'h00, rx_data);
            tmo_cnt  <= '0;
            byte_cnt <= '0;
          end
        end
        S_ADDR, S_DATA, S_CHK: begin
          if (rx_valid) begin
            crc_acc <= crc8_byte(crc_acc, rx_data);
            tmo_cnt <= '0;
            if (state == S_ADDR) addr_r <= rx_data;
            if (state == S_DATA) begin
              wdata_r[{byte_cnt, 3'b000} +: 8] <= rx_data;
              byte_cnt <= byte_cnt + 2'd1;
            end
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        S_EXEC: begin
          resp_idx <= '0;
          if (is_write) begin
            resp_buf[0] <= ACK;
            resp_buf[1] <= ACK_CRC;
            resp_last   <= crc_mode ? 3'd1 : 3'd0;
          end else begin
            resp_buf[0] <= csr_rdata[7:0];
            resp_buf[1] <= csr_rdata[15:8];
            resp_buf[2] <= csr_rdata[23:16];
            resp_buf[3] <= csr_rdata[31:24];
            resp_buf[4] <= crc8_word(csr_rdata);
            resp_last   <= crc_mode ? 3'd4 : 3'd3;
          end
        end
        S_RESP: begin
          if (tx_ready) resp_idx <= resp_idx + 3'd1;
        end
        default: ;
      endcase
      if (nak) begin
        resp_buf[0] <= nak_code;
        resp_last   <= '0;
        resp_idx    <= '0;
      end
    end
  end

  assign busy      = (state != S_IDLE);
  assign tx_valid  = (state == S_RESP);
  assign tx_data   = tx_valid ? resp_buf[resp_idx] : '0;
  assign csr_wen   = (state == S_EXEC) && is_write;
  assign csr_ren   = (state == S_EXEC) && !is_write;
  assign csr_addr  = ADDR_W'(addr_r);
  assign csr_wdata = wdata_r;

endmodule

// File: tb/tb_csr_uart_master.sv
// Testbench for csr_uart_master: directed frames against a small CSR model,
// with a posedge monitor logging strobes, pulses and transmitted bytes.
module tb_csr_uart_master;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        crc_en;
  logic        csr_wen, csr_ren;
  logic [7:0]  csr_addr;
  logic [31:0] csr_wdata, csr_rdata;
  logic        rx_crc_error, rx_illegal_cmd, rx_overrun, busy;

  always #5 clk = ~clk;

  csr_uart_master #(.ADDR_W(8), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .crc_en(crc_en),
    .csr_wen(csr_wen), .csr_ren(csr_ren), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .rx_crc_error(rx_crc_error),
    .rx_illegal_cmd(rx_illegal_cmd), .rx_overrun(rx_overrun), .busy(busy)
  );

  // CSR model: register 0x2C resets to 0x3F800000, everything else to 0
  bit [31:0] mem [64];
  bit        wr  [64];
  always_comb begin
    if (wr[csr_addr[7:2]])      csr_rdata = mem[csr_addr[7:2]];
    else if (csr_addr == 8'h2C) csr_rdata = 32'h3F800000;
    else                        csr_rdata = 32'h0;
  end

  // Monitor (sole writer of everything below)
  int         cyc = 0, n_wen = 0, n_ren = 0, n_crc = 0, n_ill = 0, n_ovr = 0, tx_n = 0;
  int         wen_cyc = 0, ren_cyc = 0, last_rx_cyc = 0, first_tx_cyc = 0;
  logic [7:0] wen_addr = '0, ren_addr = '0;
  logic [31:0] wen_data = '0;
  logic [7:0] tx_log [1024];
  logic       txv_q = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (rx_valid) last_rx_cyc = cyc;
    if (csr_wen) begin
      n_wen++; wen_cyc = cyc; wen_addr = csr_addr; wen_data = csr_wdata;
      mem[csr_addr[7:2]] = csr_wdata; wr[csr_addr[7:2]] = 1'b1;
    end
    if (csr_ren) begin n_ren++; ren_cyc = cyc; ren_addr = csr_addr; end
    if (rx_crc_error)   n_crc++;
    if (rx_illegal_cmd) n_ill++;
    if (rx_overrun)     n_ovr++;
    if (tx_valid && !txv_q) first_tx_cyc = cyc;
    if (tx_valid && tx_ready && tx_n < 1024) begin tx_log[tx_n] = tx_data; tx_n++; end
    txv_q = tx_valid;
  end

  int n_chk = 0, n_pass = 0;
  int b_wen, b_ren, b_crc, b_ill, b_ovr, b_tx;
  logic [7:0] frame [$];

  task automatic snap();
    b_wen = n_wen; b_ren = n_ren; b_crc = n_crc; b_ill = n_ill; b_ovr = n_ovr; b_tx = tx_n;
  endtask

  task automatic send_frame();
    foreach (frame[i]) begin
      @(negedge clk); rx_valid = 1'b1; rx_data = frame[i];
    end
    @(negedge clk); rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 300 && busy; k++) @(negedge clk);
  endtask

  function automatic logic [31:0] tx_word(input int b);
    return {tx_log[b+3], tx_log[b+2], tx_log[b+1], tx_log[b]};
  endfunction

  function automatic logic [7:0] tb_crc(input logic [7:0] q [$]);
    logic [7:0] c = 8'h00;
    foreach (q[i]) begin
      c ^= q[i];
      for (int j = 0; j < 8; j++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b1; crc_en = 1'b0;
    #3;
    n_chk++;
    if ({tx_valid, tx_data, csr_wen, csr_ren, csr_addr, csr_wdata, rx_crc_error,
         rx_illegal_cmd, rx_overrun, busy} !== '0)
      $display("FAIL reset_outputs: got tx_valid=%b tx_data=%h busy=%b addr=%h", tx_valid, tx_data, busy, csr_addr);
    else n_pass++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({busy, tx_valid} !== 2'b00) $display("FAIL reset_release: busy/tx_valid=%b required 00", {busy, tx_valid});
    else n_pass++;
  endtask

  task automatic test_read_crc();
    snap(); crc_en = 1'b1;
    frame = '{8'h52, 8'h3C, 8'h92};
    send_frame(); wait_idle();
    n_chk++; if (n_ren - b_ren !== 1) $display("FAIL rdcrc_ren_count: got %0d required 1", n_ren - b_ren); else n_pass++;
    n_chk++; if (ren_addr !== 8'h3C) $display("FAIL rdcrc_addr: got %h required 3c", ren_addr); else n_pass++;
    n_chk++; if (ren_cyc !== last_rx_cyc + 1) $display("FAIL rdcrc_latency: got %0d required %0d", ren_cyc, last_rx_cyc + 1); else n_pass++;
    n_chk++; if (tx_n - b_tx !== 5) $display("FAIL rdcrc_tx_count: got %0d required 5", tx_n - b_tx); else n_pass++;
    n_chk++; if ({tx_log[b_tx+4], tx_word(b_tx)} !== 40'h0) $display("FAIL rdcrc_tx_bytes: got %h required 0000000000", {tx_log[b_tx+4], tx_word(b_tx)}); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL rdcrc_busy: got %b required 0", busy); else n_pass++;
  endtask

  task automatic test_read_nocrc();
    snap(); crc_en = 1'b0;
    frame = '{8'h52, 8'h2C};
    send_frame(); wait_idle();
    n_chk++; if (n_ren - b_ren !== 1 || ren_addr !== 8'h2C) $display("FAIL rd_ren: got count %0d addr %h required 1 2c", n_ren - b_ren, ren_addr); else n_pass++;
    n_chk++; if (tx_n - b_tx !== 4) $display("FAIL rd_tx_count: got %0d required 4", tx_n - b_tx); else n_pass++;
    n_chk++; if (tx_word(b_tx) !== 32'h3F800000) $display("FAIL rd_tx_data: got %h required 3f800000", tx_word(b_tx)); else n_pass++;
  endtask

  task automatic test_write();
    snap(); crc_en = 1'b0;
    frame = '{8'h57, 8'h04, 8'h78, 8'h56, 8'h34, 8'h12};
    send_frame(); wait_idle();
    n_chk++; if (n_wen - b_wen !== 1) $display("FAIL wr_wen_count: got %0d required 1", n_wen - b_wen); else n_pass++;
    n_chk++; if ({wen_addr, wen_data} !== {8'h04, 32'h12345678}) $display("FAIL wr_addr_data: got %h %h required 04 12345678", wen_addr, wen_data); else n_pass++;
    n_chk++; if (wen_cyc !== last_rx_cyc + 1) $display("FAIL wr_exec_latency: got %0d required %0d", wen_cyc, last_rx_cyc + 1); else n_pass++;
    n_chk++; if (first_tx_cyc !== last_rx_cyc + 2) $display("FAIL wr_tx_latency: got %0d required %0d", first_tx_cyc, last_rx_cyc + 2); else n_pass++;
    n_chk++; if (tx_n - b_tx !== 1 || tx_log[b_tx] !== 8'hAC) $display("FAIL wr_ack: got count %0d byte %h required 1 ac", tx_n - b_tx, tx_log[b_tx]); else n_pass++;
    n_chk++; if (n_ren !== b_ren) $display("FAIL wr_no_ren: got %0d required 0", n_ren - b_ren); else n_pass++;
    snap();
    frame = '{8'h52, 8'h04};
    send_frame(); wait_idle();
    n_chk++; if (tx_n - b_tx !== 4 || tx_word(b_tx) !== 32'h12345678) $display("FAIL wr_readback: got %h required 12345678", tx_word(b_tx)); else n_pass++;
  endtask

  task automatic test_write_crc();
    snap(); crc_en = 1'b1;
    frame = '{8'h57, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04};
    frame.push_back(tb_crc(frame));
    send_frame(); wait_idle();
    n_chk++; if (n_wen - b_wen !== 1 || wen_data !== 32'h04030201) $display("FAIL wrcrc_wen: got count %0d data %h required 1 04030201", n_wen - b_wen, wen_data); else n_pass++;
    n_chk++; if (tx_n - b_tx !== 2 || {tx_log[b_tx], tx_log[b_tx+1]} !== 16'hAC4D) $display("FAIL wrcrc_ack: got %h required ac4d", {tx_log[b_tx], tx_log[b_tx+1]}); else n_pass++;
  endtask

  task automatic test_bad_crc();
    snap(); crc_en = 1'b1;
    frame = '{8'h52, 8'h3C, 8'h00};
    send_frame(); wait_idle();
    n_chk++; if (n_crc - b_crc !== 1 || n_ill !== b_ill) $display("FAIL badcrc_pulses: got crc %0d ill %0d required 1 0", n_crc - b_crc, n_ill - b_ill); else n_pass++;
    n_chk++; if (tx_n - b_tx !== 1 || tx_log[b_tx] !== 8'hE1) $display("FAIL badcrc_nak: got count %0d byte %h required 1 e1", tx_n - b_tx, tx_log[b_tx]); else n_pass++;
    n_chk++; if (n_ren !== b_ren) $display("FAIL badcrc_no_ren: got %0d required 0", n_ren - b_ren); else n_pass++;
  endtask

  task automatic test_unaligned();
    snap(); crc_en = 1'b0;
    frame = '{8'h52, 8'h3D};
    send_frame(); wait_idle();
    n_chk++; if (n_ill - b_ill !== 1 || n_crc !== b_crc) $display("FAIL unal_pulses: got ill %0d crc %0d required 1 0", n_ill - b_ill, n_crc - b_crc); else n_pass++;
    n_chk++; if (tx_n - b_tx !== 1 || tx_log[b_tx] !== 8'hE2) $display("FAIL unal_nak: got count %0d byte %h required 1 e2", tx_n - b_tx, tx_log[b_tx]); else n_pass++;
    n_chk++; if (n_ren !== b_ren || n_wen !== b_wen) $display("FAIL unal_no_strobe: got ren %0d wen %0d required 0 0", n_ren - b_ren, n_wen - b_wen); else n_pass++;
  endtask

  task automatic test_illegal_op();
    snap(); crc_en = 1'b1;
    frame = '{8'hFF};
    send_frame(); wait_idle();
    n_chk++; if (n_ill - b_ill !== 1) $display("FAIL illop_pulse: got %0d required 1", n_ill - b_ill); else n_pass++;
    n_chk++; if (tx_n - b_tx !== 1 || tx_log[b_tx] !== 8'hE2) $display("FAIL illop_nak: got count %0d byte %h required 1 e2", tx_n - b_tx, tx_log[b_tx]); else n_pass++;
  endtask

  task automatic test_timeout();
    snap(); crc_en = 1'b0;
    frame = '{8'h57, 8'h04};
    send_frame();
    repeat (10) @(negedge clk);
    n_chk++; if (busy !== 1'b1) $display("FAIL tmo_early: busy got %b required 1", busy); else n_pass++;
    repeat (10) @(negedge clk);
    n_chk++; if (busy !== 1'b0) $display("FAIL tmo_idle: busy got %b required 0", busy); else n_pass++;
    n_chk++; if (n_ill - b_ill !== 1) $display("FAIL tmo_pulse: got %0d required 1", n_ill - b_ill); else n_pass++;
    n_chk++; if (tx_n !== b_tx || n_wen !== b_wen) $display("FAIL tmo_silent: got tx %0d wen %0d required 0 0", tx_n - b_tx, n_wen - b_wen); else n_pass++;
    snap();
    frame = '{8'h52, 8'h2C};
    send_frame(); wait_idle();
    n_chk++; if (tx_n - b_tx !== 4 || tx_word(b_tx) !== 32'h3F800000) $display("FAIL tmo_recover: got %h required 3f800000", tx_word(b_tx)); else n_pass++;
  endtask

  task automatic test_backpressure_overrun();
    logic [7:0] hold;
    bit         stable;
    snap(); crc_en = 1'b0; tx_ready = 1'b0;
    frame = '{8'h52, 8'h2C};
    send_frame();
    for (int k = 0; k < 50 && !tx_valid; k++) @(negedge clk);
    n_chk++; if (tx_valid !== 1'b1) $display("FAIL bp_tx_valid: got %b required 1", tx_valid); else n_pass++;
    hold = tx_data; stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 3) begin rx_valid = 1'b1; rx_data = 8'h55; end
      if (i == 4) rx_valid = 1'b0;
      if (tx_data !== hold || tx_valid !== 1'b1) stable = 1'b0;
    end
    n_chk++; if (!stable || hold !== 8'h00) $display("FAIL bp_stable: got stable=%b first=%h required 1 00", stable, hold); else n_pass++;
    n_chk++; if (n_ovr - b_ovr !== 1) $display("FAIL ovr_pulse: got %0d required 1", n_ovr - b_ovr); else n_pass++;
    n_chk++; if (tx_n !== b_tx) $display("FAIL bp_no_handshake: got %0d required 0", tx_n - b_tx); else n_pass++;
    tx_ready = 1'b1;
    wait_idle();
    n_chk++; if (tx_n - b_tx !== 4 || tx_word(b_tx) !== 32'h3F800000) $display("FAIL ovr_resp: got count %0d data %h required 4 3f800000", tx_n - b_tx, tx_word(b_tx)); else n_pass++;
    n_chk++; if (n_ill !== b_ill || busy !== 1'b0) $display("FAIL ovr_state: got ill %0d busy %b required 0 0", n_ill - b_ill, busy); else n_pass++;
  endtask

  task automatic test_reset_mid();
    snap(); crc_en = 1'b0;
    frame = '{8'h57, 8'h04, 8'h11, 8'h22};
    send_frame();
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({tx_valid, tx_data, csr_wen, csr_ren, csr_addr, csr_wdata, rx_crc_error,
         rx_illegal_cmd, rx_overrun, busy} !== '0)
      $display("FAIL midrst_outputs: got busy=%b addr=%h wdata=%h required 0", busy, csr_addr, csr_wdata);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if (n_wen !== b_wen || tx_n !== b_tx) $display("FAIL midrst_discard: got wen %0d tx %0d required 0 0", n_wen - b_wen, tx_n - b_tx); else n_pass++;
    frame = '{8'h57, 8'h10, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_frame(); wait_idle();
    n_chk++; if (n_wen - b_wen !== 1 || {wen_addr, wen_data} !== {8'h10, 32'hDDCCBBAA}) $display("FAIL midrst_write: got %h %h required 10 ddccbbaa", wen_addr, wen_data); else n_pass++;
    n_chk++; if (tx_n - b_tx !== 1 || tx_log[b_tx] !== 8'hAC) $display("FAIL midrst_ack: got count %0d byte %h required 1 ac", tx_n - b_tx, tx_log[b_tx]); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_read_crc();
    test_read_nocrc();
    test_write();
    test_write_crc();
    test_bad_crc();
    test_unaligned();
    test_illegal_op();
    test_timeout();
    test_backpressure_overrun();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
